// File: rtl/addsub_seq_if.sv
// Operand/result bundle for addsub_seq: the requester drives start/A/B/M,
// the adder returns busy/done, the registered result S and the flags C/V/N/Z.
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             M;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             C;
  logic             V;
  logic             N;
  logic             Z;

  modport master (
    output start, A, B, M,
    input  busy, done, S, C, V, N, Z
  );

  modport slave (
    input  start, A, B, M,
    output busy, done, S, C, V, N, Z
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: computes A+B or A-B one SLICE-wide slice per
// clock, LSB slice first, then publishes S and the C/V/N/Z flags with a done pulse.
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  addsub_seq_if.slave        bus,
  output logic [1:0]         state_dbg
);
  // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
  // DONE); busy is high exactly during the NS computing cycles and done is a
  // one-cycle pulse in which S and the flags have just been updated.

  localparam int NS = WIDTH / SLICE;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             capture;
  logic             last_slice;
  logic [WIDTH-1:0] a_q, bx_q, acc_q, res_d;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  logic [SLICE-1:0] sl_a, sl_b;
  logic [SLICE:0]   slice_sum;
  int               lo;
  logic [WIDTH-1:0] s_q;
  logic             c_q, v_q, n_q, z_q;

  assign last_slice = (idx_q == IW'(NS - 1));

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          capture = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Current slice is picked by shifting; the partial result is merged back
  // into the accumulator under a slice mask at the same bit offset.
  always_comb begin
    lo        = int'(idx_q) * SLICE;
    sl_a      = SLICE'(a_q >> lo);
    sl_b      = SLICE'(bx_q >> lo);
    slice_sum = {1'b0, sl_a} + {1'b0, sl_b} + (SLICE + 1)'(carry_q);
    res_d     = (acc_q & ~(WIDTH'({SLICE{1'b1}}) << lo))
              | (WIDTH'(slice_sum[SLICE-1:0]) << lo);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        a_q     <= bus.A;
        bx_q    <= bus.M ? ~bus.B : bus.B;
        carry_q <= bus.M;
        idx_q   <= '0;
        acc_q   <= '0;
      end else if (state_q == CALC) begin
        acc_q   <= res_d;
        carry_q <= slice_sum[SLICE];
        idx_q   <= idx_q + IW'(1);
        if (last_slice) begin
          s_q <= res_d;
          c_q <= slice_sum[SLICE];
          v_q <= (a_q[WIDTH-1] & bx_q[WIDTH-1] & ~res_d[WIDTH-1])
               | (~a_q[WIDTH-1] & ~bx_q[WIDTH-1] & res_d[WIDTH-1]);
          n_q <= res_d[WIDTH-1];
          z_q <= ~|res_d;
        end
      end
    end
  end

  assign bus.busy  = (state_q == CALC);
  assign bus.done  = (state_q == DONE);
  assign bus.S     = s_q;
  assign bus.C     = c_q;
  assign bus.V     = v_q;
  assign bus.N     = n_q;
  assign bus.Z     = z_q;
  assign state_dbg = state_q;
endmodule
